// File: rtl/uart_rx_oversampled.sv
// UART receiver with a 2-flop input synchronizer, mid-bit sampling and parity/stop checks.
// Frame: start, INPUT_DATA_WIDTH data bits LSB-first, parity, stop; CLOCKS_PER_STATE clk per bit.
module uart_rx_oversampled #(
   parameter int unsigned INPUT_DATA_WIDTH = 8,
   parameter int unsigned CLOCKS_PER_STATE = 8,
   parameter bit          PARITY_ODD       = 1'b0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        serial_in,
   output logic [INPUT_DATA_WIDTH-1:0] received_data,
   output logic                        data_is_valid,
   output logic                        rx_error,
   output logic                        rx_busy
);

   localparam int unsigned CW = $clog2(CLOCKS_PER_STATE);
   localparam int unsigned BW = $clog2(INPUT_DATA_WIDTH + 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(CLOCKS_PER_STATE / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_STATE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(INPUT_DATA_WIDTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                      state_q, state_d;
   logic [1:0]                  sync_q, sync_d;
   logic [CW-1:0]               cyc_q, cyc_d;
   logic [BW-1:0]               bit_q, bit_d;
   logic [INPUT_DATA_WIDTH-1:0] shift_q, shift_d;
   logic                        par_q, par_d;
   logic [INPUT_DATA_WIDTH-1:0] data_q, data_d;
   logic                        valid_q, valid_d;
   logic                        err_q, err_d;
   logic                        rx_s, mid, last;

   assign rx_s = sync_q[1];
   assign mid  = (cyc_q == CNT_MID);
   assign last = (cyc_q == CNT_LAST);

   always_comb begin
      sync_d  = {sync_q[0], serial_in};
      state_d = state_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      if (state_q != S_IDLE) cyc_d = last ? '0 : cyc_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            cyc_d = '0;
            bit_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            if (mid && rx_s) begin
               state_d = S_IDLE;
               cyc_d   = '0;
            end else if (last) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (mid) shift_d = {rx_s, shift_q[INPUT_DATA_WIDTH-1:1]};
            if (last) begin
               bit_d = bit_q + 1'b1;
               if (bit_q == BIT_LAST) state_d = S_PARITY;
            end
         end
         S_PARITY: begin
            if (mid) par_d = rx_s;
            if (last) state_d = S_STOP;
         end
         S_STOP: begin
            // Leave at mid-stop so a start bit directly after the stop bit is caught.
            if (mid) begin
               state_d = S_IDLE;
               cyc_d   = '0;
               if (rx_s && (par_q == ((^shift_q) ^ PARITY_ODD))) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         sync_q  <= '1;
         cyc_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         cyc_q   <= cyc_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign received_data = data_q;
   assign data_is_valid = valid_q;
   assign rx_error      = err_q;
   assign rx_busy       = (state_q != S_IDLE);

endmodule
